// File: rtl/vga_pixel_timing.sv
// vga_pixel_timing: 640x480@60 VGA timing generator and one-pixel-ahead
// fetch engine. It runs on the 100 MHz system clock and uses an internal
// 1-in-DIV clock enable rather than a derived pixel clock.
//
// Optional build macro VGA_UNDERRUN_COUNT_EN adds the saturating 16-bit
// underrun_cnt output next to the sticky underrun flag.
module vga_pixel_timing #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int DIV      = 4,
  parameter int RGB_W    = 12
) (
  input  logic             clk_100,
  input  logic             rst_n,
  output logic             pix_req,
  output logic [9:0]       req_x,
  output logic [9:0]       req_y,
  input  logic             pix_valid,
  input  logic [RGB_W-1:0] pix_data,
  input  logic             underrun_clr,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic [RGB_W-1:0] rgb,
  output logic             frame_start,
  output logic             underrun
`ifdef VGA_UNDERRUN_COUNT_EN
  ,
  output logic [15:0]      underrun_cnt
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = $clog2(DIV);

  localparam logic [9:0]       H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]       V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]       H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0]       V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0]       HS_BEG   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0]       HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]       VS_BEG   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]       VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

  // True when pos lies in the half-open window [lo, hi).
  function automatic logic in_win(input logic [9:0] pos,
                                  input logic [9:0] lo,
                                  input logic [9:0] hi);
    return (pos >= lo) && (pos < hi);
  endfunction

  // True when (h, v) is inside the visible area.
  function automatic logic is_vis(input logic [9:0] h, input logic [9:0] v);
    return (h < H_VIS) && (v < V_VIS);
  endfunction

  logic [DIV_W-1:0] div_cnt;
  logic             ce;
  logic [9:0]       h_cnt;
  logic [9:0]       v_cnt;
  logic [9:0]       h_nxt;
  logic [9:0]       v_nxt;
  logic             cur_vis;
  logic             nxt_vis;
  logic             outstanding;
  logic             buf_vld;
  logic [RGB_W-1:0] pix_buf;
  logic             take;
  logic             miss;

  assign ce      = (div_cnt == DIV_LAST);
  assign cur_vis = is_vis(h_cnt, v_cnt);
  assign nxt_vis = is_vis(h_nxt, v_nxt);
  // Data is only accepted strictly before the ce that consumes it.
  assign take    = pix_valid && outstanding && !ce;
  // A visible slot is being displayed without data in the buffer.
  assign miss    = ce && cur_vis && !buf_vld;

  // Pixel clock-enable divider.
  always_ff @(posedge clk_100 or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (ce) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // Position after the current one, wrapping at line and frame ends.
  always_comb begin
    h_nxt = h_cnt + 10'd1;
    v_nxt = v_cnt;
    if (h_cnt == H_LAST) begin
      h_nxt = 10'd0;
      v_nxt = (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
    end
  end

  // Fetch position counters; reset to the last slot so the first ce lands on (0,0).
  always_ff @(posedge clk_100 or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= H_LAST;
      v_cnt <= V_LAST;
    end else if (ce) begin
      h_cnt <= h_nxt;
      v_cnt <= v_nxt;
    end
  end

  // Display registers: decode of the pre-advance position, loaded on ce.
  always_ff @(posedge clk_100 or negedge rst_n) begin
    if (!rst_n) begin
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      de          <= 1'b0;
      rgb         <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= ce && (h_cnt == 10'd0) && (v_cnt == 10'd0);
      if (ce) begin
        hsync <= !in_win(h_cnt, HS_BEG, HS_END);
        vsync <= !in_win(v_cnt, VS_BEG, VS_END);
        de    <= cur_vis;
        rgb   <= (cur_vis && buf_vld) ? pix_buf : '0;
      end
    end
  end

  // Fetch strobe and coordinates for the next visible pixel.
  always_ff @(posedge clk_100 or negedge rst_n) begin
    if (!rst_n) begin
      pix_req <= 1'b0;
      req_x   <= 10'd0;
      req_y   <= 10'd0;
    end else begin
      pix_req <= ce && nxt_vis;
      if (ce && nxt_vis) begin
        req_x <= h_nxt;
        req_y <= v_nxt;
      end
    end
  end

  // Request tracking and buffer valid bit; first response per request wins.
  always_ff @(posedge clk_100 or negedge rst_n) begin
    if (!rst_n) begin
      outstanding <= 1'b0;
      buf_vld     <= 1'b0;
    end else if (ce) begin
      outstanding <= nxt_vis;
      buf_vld     <= 1'b0;
    end else if (take) begin
      outstanding <= 1'b0;
      buf_vld     <= 1'b1;
    end
  end

  // Buffer payload; qualified by buf_vld so it needs no reset.
  always_ff @(posedge clk_100) begin
    if (take) begin
      pix_buf <= pix_data;
    end
  end

  // Sticky underrun flag; a new miss outranks a simultaneous clear.
  always_ff @(posedge clk_100 or negedge rst_n) begin
    if (!rst_n) begin
      underrun <= 1'b0;
    end else if (miss) begin
      underrun <= 1'b1;
    end else if (underrun_clr) begin
      underrun <= 1'b0;
    end
  end

`ifdef VGA_UNDERRUN_COUNT_EN
  // Saturating underrun event counter; a miss during clear counts as the first new event.
  always_ff @(posedge clk_100 or negedge rst_n) begin
    if (!rst_n) begin
      underrun_cnt <= 16'd0;
    end else if (underrun_clr) begin
      underrun_cnt <= miss ? 16'd1 : 16'd0;
    end else if (miss && (underrun_cnt != 16'hFFFF)) begin
      underrun_cnt <= underrun_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vga_pixel_timing.sv
// Directed testbench for vga_pixel_timing using a reduced timing set so
// whole frames fit in a short run. Expected values come from the timing
// equations evaluated on the bench's own pixel walk.
module tb_vga_pixel_timing;

  localparam int HA = 16, HF = 2, HS = 3, HB = 3;
  localparam int VA = 6,  VF = 1, VS = 2, VB = 2;
  localparam int DV = 4,  RW = 12;
  localparam int HT = HA + HF + HS + HB;   // 24 pixels per line
  localparam int VT = VA + VF + VS + VB;   // 11 lines per frame
  localparam int FRAME_CYC = HT * VT * DV; // 1056 clk_100 cycles

  logic          clk_100 = 1'b0;
  logic          rst_n = 1'b0;
  logic          pix_req;
  logic [9:0]    req_x, req_y;
  logic          pix_valid = 1'b0;
  logic [RW-1:0] pix_data = '0;
  logic          underrun_clr = 1'b0;
  logic          hsync, vsync, de, frame_start, underrun;
  logic [RW-1:0] rgb;
`ifdef VGA_UNDERRUN_COUNT_EN
  logic [15:0]   underrun_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  // Responder controls
  bit   rsp_en = 1'b0;
  bit   spur_req = 1'b0;
  bit   dup_next = 1'b0;
  int   rsp_cnt = 0;
  int   rsp_x = 0, rsp_y = 0;
  logic [RW-1:0] rsp_data = '0;
  int   skip_x = -1, skip_y = -1;
  int   late_x = -1, late_y = -1;
  int   dup_x = -1,  dup_y = -1;

  vga_pixel_timing #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .DIV(DV), .RGB_W(RW)
  ) dut (
    .clk_100(clk_100),
    .rst_n(rst_n),
    .pix_req(pix_req),
    .req_x(req_x),
    .req_y(req_y),
    .pix_valid(pix_valid),
    .pix_data(pix_data),
    .underrun_clr(underrun_clr),
    .hsync(hsync),
    .vsync(vsync),
    .de(de),
    .rgb(rgb),
    .frame_start(frame_start),
    .underrun(underrun)
`ifdef VGA_UNDERRUN_COUNT_EN
    ,
    .underrun_cnt(underrun_cnt)
`endif
  );

  initial begin
    forever #5 clk_100 = ~clk_100;
  end

  initial begin
    #(200000 * 10);
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  // Upstream model: answers each request one cycle after pix_req, with
  // per-coordinate options to withhold, answer late, or answer twice.
  initial begin
    forever begin
      @(negedge clk_100);
      #1;
      pix_valid = 1'b0;
      if (!rsp_en) begin
        rsp_cnt  = 0;
        dup_next = 1'b0;
      end
      if (dup_next) begin
        pix_valid = 1'b1;
        pix_data  = rsp_data ^ 12'hABC;
        dup_next  = 1'b0;
      end
      if (rsp_cnt > 0) begin
        rsp_cnt--;
        if (rsp_cnt == 0) begin
          pix_valid = 1'b1;
          pix_data  = rsp_data;
          if (rsp_x == dup_x && rsp_y == dup_y) dup_next = 1'b1;
        end
      end
      if (spur_req) begin
        pix_valid = 1'b1;
        pix_data  = 12'hFFF;
        spur_req  = 1'b0;
      end
      if (rsp_en && pix_req) begin
        rsp_x    = int'(req_x);
        rsp_y    = int'(req_y);
        rsp_data = {req_y[3:0], req_x[7:0]};
        if (!(rsp_x == skip_x && rsp_y == skip_y))
          rsp_cnt = (rsp_x == late_x && rsp_y == late_y) ? 3 : 1;
      end
    end
  end

  // Walks one full frame from the frame_start pixel, checking every pixel
  // slot and the per-frame timing totals.
  task automatic scan_frame(input string tag, input bit inj_late, input bit inj_spur);
    bit ok;
    int t, de_cyc, hs_cyc, vs_cyc, req_cyc, n_rise;
    int de_rise0, de_rise1, hs_fall0, vs_fall;
    bit prev_de, prev_hs, prev_vs;
    logic [9:0] xv, yv, nx, ny;
    logic e_de, e_hs, e_vs, e_req;
    logic [RW-1:0] e_rgb;
    logic [36:0] obs, expv;
    ok = 1'b0;
    for (int i = 0; i < 3 * FRAME_CYC; i++) begin
      if (frame_start === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk_100);
    end
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s frame_start_wait: no pulse observed, required one within %0d cycles", tag, 3 * FRAME_CYC);
      return;
    end
    t = 0; de_cyc = 0; hs_cyc = 0; vs_cyc = 0; req_cyc = 0; n_rise = 0;
    de_rise0 = -1; de_rise1 = -1; hs_fall0 = -1; vs_fall = -1;
    prev_de = 1'b0; prev_hs = 1'b1; prev_vs = 1'b1;
    for (int y = 0; y < VT; y++) begin
      for (int x = 0; x < HT; x++) begin
        xv    = 10'(x);
        yv    = 10'(y);
        e_de  = (x < HA) && (y < VA);
        e_hs  = !((x >= HA + HF) && (x < HA + HF + HS));
        e_vs  = !((y >= VA + VF) && (y < VA + VF + VS));
        e_rgb = e_de ? {yv[3:0], xv[7:0]} : 12'h000;
        if (inj_late && y == 5 && (x == 10 || x == 11)) e_rgb = 12'h000;
        nx    = (x == HT - 1) ? 10'd0 : xv + 10'd1;
        ny    = (x == HT - 1) ? ((y == VT - 1) ? 10'd0 : yv + 10'd1) : yv;
        e_req = (nx < 10'(HA)) && (ny < 10'(VA));
        expv  = {e_de, e_hs, e_vs, (x == 0 && y == 0), e_rgb, e_req,
                 e_req ? nx : 10'd0, e_req ? ny : 10'd0};
        obs   = {de, hsync, vsync, frame_start, rgb, pix_req,
                 e_req ? req_x : 10'd0, e_req ? req_y : 10'd0};
        n_cmp++;
        if (obs !== expv) begin
          n_bad++;
          $display("FAIL %s pixel(%0d,%0d): {de,hs,vs,fs,rgb,req,rx,ry} got %h required %h",
                   tag, x, y, obs, expv);
        end
        for (int k = 0; k < DV; k++) begin
          if (inj_spur && x == 20 && y == 1 && k == 1) spur_req = 1'b1;
          if (de)       de_cyc++;
          if (!hsync)   hs_cyc++;
          if (!vsync)   vs_cyc++;
          if (pix_req)  req_cyc++;
          if (de && !prev_de) begin
            if (n_rise == 0) de_rise0 = t;
            else if (n_rise == 1) de_rise1 = t;
            n_rise++;
          end
          if (!hsync && prev_hs && hs_fall0 < 0) hs_fall0 = t;
          if (!vsync && prev_vs && vs_fall < 0) vs_fall = t;
          prev_de = de;
          prev_hs = hsync;
          prev_vs = vsync;
          @(negedge clk_100);
          t++;
        end
      end
    end
    n_cmp++;
    if (frame_start !== 1'b1) begin
      n_bad++;
      $display("FAIL %s frame_period: frame_start=%b after %0d cycles, required 1", tag, frame_start, t);
    end
    n_cmp++;
    if (de_cyc != HA * VA * DV) begin
      n_bad++;
      $display("FAIL %s de_cycles: got %0d required %0d", tag, de_cyc, HA * VA * DV);
    end
    n_cmp++;
    if (hs_cyc != HS * DV * VT) begin
      n_bad++;
      $display("FAIL %s hsync_low_cycles: got %0d required %0d", tag, hs_cyc, HS * DV * VT);
    end
    n_cmp++;
    if (vs_cyc != VS * HT * DV) begin
      n_bad++;
      $display("FAIL %s vsync_low_cycles: got %0d required %0d", tag, vs_cyc, VS * HT * DV);
    end
    n_cmp++;
    if (req_cyc != HA * VA) begin
      n_bad++;
      $display("FAIL %s pix_req_count: got %0d required %0d", tag, req_cyc, HA * VA);
    end
    n_cmp++;
    if (de_rise1 - de_rise0 != HT * DV) begin
      n_bad++;
      $display("FAIL %s line_period: got %0d required %0d", tag, de_rise1 - de_rise0, HT * DV);
    end
    n_cmp++;
    if (hs_fall0 - de_rise0 != (HA + HF) * DV) begin
      n_bad++;
      $display("FAIL %s de_to_hsync: got %0d required %0d", tag, hs_fall0 - de_rise0, (HA + HF) * DV);
    end
    n_cmp++;
    if (vs_fall != (VA + VF) * HT * DV) begin
      n_bad++;
      $display("FAIL %s vsync_start: got %0d required %0d", tag, vs_fall, (VA + VF) * HT * DV);
    end
  endtask

  // Power-on reset values, then first request and first frame_start latency.
  task automatic test_reset();
    logic [37:0] obs;
    int first_req, first_fs;
    logic [19:0] first_xy;
    rst_n = 1'b0;
    repeat (3) @(negedge clk_100);
    obs = {hsync, vsync, de, rgb, frame_start, pix_req, req_x, req_y, underrun};
    n_cmp++;
    if (obs !== {1'b1, 1'b1, 1'b0, 12'h000, 1'b0, 1'b0, 10'd0, 10'd0, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_values: got %h required %h", obs,
               {1'b1, 1'b1, 1'b0, 12'h000, 1'b0, 1'b0, 10'd0, 10'd0, 1'b0});
    end
`ifdef VGA_UNDERRUN_COUNT_EN
    n_cmp++;
    if (underrun_cnt !== 16'd0) begin
      n_bad++;
      $display("FAIL reset_underrun_cnt: got %0d required 0", underrun_cnt);
    end
`endif
    rst_n  = 1'b1;
    rsp_en = 1'b1;
    first_req = -1; first_fs = -1; first_xy = '1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk_100);
      if (pix_req === 1'b1 && first_req < 0) begin
        first_req = k;
        first_xy  = {req_x, req_y};
      end
      if (frame_start === 1'b1) begin
        first_fs = k;
        break;
      end
    end
    n_cmp++;
    if (first_req != 4 || first_xy !== 20'd0) begin
      n_bad++;
      $display("FAIL first_request: cycle %0d xy %h, required cycle 4 xy 00000", first_req, first_xy);
    end
    n_cmp++;
    if (first_fs != 8) begin
      n_bad++;
      $display("FAIL first_frame_start: cycle %0d, required 8", first_fs);
    end
  endtask

  // A clean frame with every pixel answered on time.
  task automatic test_frame();
    scan_frame("normal", 1'b0, 1'b0);
    n_cmp++;
    if (underrun !== 1'b0) begin
      n_bad++;
      $display("FAIL normal_underrun: got %b required 0", underrun);
    end
  endtask

  // Missing pixel at (10,5), late pixel at (11,5), then clear.
  task automatic test_underrun();
    skip_x = 10; skip_y = 5;
    late_x = 11; late_y = 5;
    scan_frame("late", 1'b1, 1'b0);
    skip_x = -1; skip_y = -1;
    late_x = -1; late_y = -1;
    n_cmp++;
    if (underrun !== 1'b1) begin
      n_bad++;
      $display("FAIL underrun_set: got %b required 1", underrun);
    end
`ifdef VGA_UNDERRUN_COUNT_EN
    n_cmp++;
    if (underrun_cnt !== 16'd2) begin
      n_bad++;
      $display("FAIL underrun_cnt: got %0d required 2", underrun_cnt);
    end
`endif
    underrun_clr = 1'b1;
    @(negedge clk_100);
    underrun_clr = 1'b0;
    n_cmp++;
    if (underrun !== 1'b0) begin
      n_bad++;
      $display("FAIL underrun_clear: got %b required 0", underrun);
    end
`ifdef VGA_UNDERRUN_COUNT_EN
    n_cmp++;
    if (underrun_cnt !== 16'd0) begin
      n_bad++;
      $display("FAIL underrun_cnt_clear: got %0d required 0", underrun_cnt);
    end
`endif
  endtask

  // Duplicate response at (3,2) and a stray strobe in horizontal blanking.
  task automatic test_dup_spur();
    dup_x = 3; dup_y = 2;
    scan_frame("dup_spur", 1'b0, 1'b1);
    dup_x = -1; dup_y = -1;
    n_cmp++;
    if (underrun !== 1'b0) begin
      n_bad++;
      $display("FAIL dup_spur_underrun: got %b required 0", underrun);
    end
  endtask

  // Reset mid-line with a request for (12,2) outstanding.
  task automatic test_reset_midline();
    bit ok;
    logic [37:0] obs;
    int first_req, first_fs;
    logic [19:0] first_xy;
    ok = 1'b0;
    for (int i = 0; i < 3 * FRAME_CYC; i++) begin
      @(negedge clk_100);
      if (pix_req === 1'b1 && req_x === 10'd12 && req_y === 10'd2) begin
        ok = 1'b1;
        break;
      end
    end
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL midline_wait: request (12,2) not seen, required within %0d cycles", 3 * FRAME_CYC);
      return;
    end
    rsp_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    obs = {hsync, vsync, de, rgb, frame_start, pix_req, req_x, req_y, underrun};
    n_cmp++;
    if (obs !== {1'b1, 1'b1, 1'b0, 12'h000, 1'b0, 1'b0, 10'd0, 10'd0, 1'b0}) begin
      n_bad++;
      $display("FAIL midline_reset_values: got %h required %h", obs,
               {1'b1, 1'b1, 1'b0, 12'h000, 1'b0, 1'b0, 10'd0, 10'd0, 1'b0});
    end
    repeat (3) @(negedge clk_100);
    rst_n    = 1'b1;
    spur_req = 1'b1;
    first_req = -1; first_fs = -1; first_xy = '1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk_100);
      if (k == 1) rsp_en = 1'b1;
      if (pix_req === 1'b1 && first_req < 0) begin
        first_req = k;
        first_xy  = {req_x, req_y};
      end
      if (frame_start === 1'b1) begin
        first_fs = k;
        break;
      end
    end
    n_cmp++;
    if (first_req != 4 || first_xy !== 20'd0) begin
      n_bad++;
      $display("FAIL midline_first_request: cycle %0d xy %h, required cycle 4 xy 00000", first_req, first_xy);
    end
    n_cmp++;
    if (first_fs != 8) begin
      n_bad++;
      $display("FAIL midline_frame_start: cycle %0d, required 8", first_fs);
    end
    scan_frame("after_reset", 1'b0, 1'b0);
    n_cmp++;
    if (underrun !== 1'b0) begin
      n_bad++;
      $display("FAIL after_reset_underrun: got %b required 0", underrun);
    end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_underrun();
    test_dup_spur();
    test_reset_midline();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
